// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: load/store sizes, FSM states,
// fault causes, plus helpers for request validation and load formatting.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_DATA = 1'b1
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_FUNC3    = 3'd2;
    localparam logic [2:0] FC_MISALIGN = 3'd3;
    localparam logic [2:0] FC_RANGE    = 3'd4;

    function automatic logic [2:0] fault_cause(input logic        rd,
                                               input logic        wr,
                                               input logic [2:0]  f3,
                                               input logic [31:0] addr,
                                               input logic [31:0] depth);
        logic [2:0] c;
        c = FC_NONE;
        if (rd && wr) begin
            c = FC_CONFLICT;
        end else if ((f3 == 3'b011) || (f3[2:1] == 2'b11)) begin
            c = FC_FUNC3;
        end else if ((f3[1:0] == 2'b01) && addr[0]) begin
            c = FC_MISALIGN;
        end else if ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) begin
            c = FC_MISALIGN;
        end else if ({2'b00, addr[31:2]} >= depth) begin
            c = FC_RANGE;
        end else begin
            c = FC_NONE;
        end
        return c;
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LBU:  r = {24'h000000, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LHU:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and
// registered read data; contents are never reset.
module data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // byte-lane writes and read-before-write registered output
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit front-end: validates requests, drives byte-lane stores and
// two-cycle loads (stall, then formatted data) against data_ram.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_fault
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  func3_q, func3_d;

    logic [2:0]  cause;
    logic        req_ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;

    assign cause = fault_cause(mem_read, mem_write, func3, addr, 32'(DEPTH_WORDS));

    // request decode, store lanes, next state and outputs
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        func3_d      = func3_q;
        be           = 4'b0000;
        wdata        = write_data;
        stall        = 1'b0;
        access_fault = 1'b0;
        read_data    = 32'h0000_0000;
        req_ok       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && (mem_read || mem_write)) begin
                    if (cause != FC_NONE) begin
                        access_fault = 1'b1;
                    end else begin
                        req_ok = 1'b1;
                    end
                end else begin
                    req_ok = 1'b0;
                end
                if (req_ok && mem_read) begin
                    stall   = 1'b1;
                    state_d = LOAD_DATA;
                    off_d   = addr[1:0];
                    func3_d = func3;
                end else if (req_ok && mem_write) begin
                    case (func3[1:0])
                        2'b00: begin
                            be    = 4'b0001 << addr[1:0];
                            wdata = {4{write_data[7:0]}};
                        end
                        2'b01: begin
                            be    = addr[1] ? 4'b1100 : 4'b0011;
                            wdata = {2{write_data[15:0]}};
                        end
                        default: be = 4'b1111;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_DATA: begin
                read_data = load_format(ram_rdata, off_q, func3_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and captured load attributes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            off_q   <= 2'b00;
            func3_q <= 3'b000;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            func3_q <= func3_d;
        end
    end

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .be    (be),
        .idx   (addr[AW+1:2]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed table-driven bench for data_mem_ctrl plus back-to-back load and
// reset-during-load sequences.
module tb_data_mem_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, write_data, read_data;
    logic        stall, access_fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        st;
        logic        af;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl[$];

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .func3        (func3),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .stall        (stall),
        .access_fault (access_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_read   = rd;
        mem_write  = wr;
        func3      = f3;
        addr       = a;
        write_data = wd;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic st, input logic af, input logic [31:0] rdat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
        v.st = st; v.af = af; v.rdat = rdat;
        return v;
    endfunction

    initial begin
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        int          stall_cnt;

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000;
        addr = 32'h0; write_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_fault", {31'h0, access_fault}, 32'h0);
        chk("reset_rdata", read_data, 32'h0);
        rst = 1'b0;

        // rd wr f3 addr wdata | stall fault read_data
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h00, 32'h11111111, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h20, 32'h00000000, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'hFFFFFF80));
        tbl.push_back(mk(1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'h00000080));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'h80ADBEEF));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'hFFFFFFEF));
        tbl.push_back(mk(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b001, 32'h22, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'hFFFFABCD));
        tbl.push_back(mk(1'b1, 1'b0, 3'b101, 32'h22, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0000ABCD));
        // rejected requests: misaligned, conflicting, illegal func3, out of range
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h11, 32'h0,        1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000FFFF, 1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 3'b010, 32'h10, 32'h00000000, 1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h1000, 32'h55555555, 1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0,      1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0));
        // memory unchanged by the rejected requests
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h00, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'h11111111));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'h80ADBEEF));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b0, 1'b0, 32'hABCD0000));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d_stall", i), {31'h0, stall}, {31'h0, tbl[i].st});
            chk($sformatf("vec%0d_fault", i), {31'h0, access_fault}, {31'h0, tbl[i].af});
            chk($sformatf("vec%0d_rdata", i), read_data, tbl[i].rdat);
        end

        // back-to-back loads: core re-presents each load during its data cycle
        b2b_addr[0] = 32'h10; b2b_data[0] = 32'h80ADBEEF;
        b2b_addr[1] = 32'h00; b2b_data[1] = 32'h11111111;
        b2b_addr[2] = 32'h20; b2b_data[2] = 32'hABCD0000;
        stall_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, 3'b010, b2b_addr[c/2], 32'h0);
            if (stall) stall_cnt++;
            chk($sformatf("b2b%0d_stall", c), {31'h0, stall}, {31'h0, ((c % 2) == 0)});
            chk($sformatf("b2b%0d_rdata", c), read_data,
                ((c % 2) == 1) ? b2b_data[c/2] : 32'h0);
        end
        chk("b2b_stall_count", 32'(stall_cnt), 32'd3);

        // reset asserted while in LOAD_DATA, with a store attempt held during reset
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("rl_issue_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b010;
        addr = 32'h10; write_data = 32'h0;
        #1;
        chk("rl_rdata", read_data, 32'h0);
        chk("rl_stall", {31'h0, stall}, 32'h0);
        chk("rl_fault", {31'h0, access_fault}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rl_hold_rdata", read_data, 32'h0);
        rst = 1'b0;
        mem_write = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("post_rst_stall", {31'h0, stall}, 32'h1);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("post_rst_rdata", read_data, 32'h80ADBEEF);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("post_rst_idle_rdata", read_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
